// File: rtl/vgachargen_map_ctrl.sv
// Character/colour map port owner: arbitrates single-beat bus accesses against the
// FILL and SCROLL bulk engine that rewrites the whole screen.
module vgachargen_map_ctrl #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = $clog2(COLS * ROWS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              bus_req_i,
    input  logic              bus_we_i,
    input  logic              bus_sel_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [7:0]        bus_wdata_i,
    output logic              bus_gnt_o,
    output logic              bus_rvalid_o,
    output logic [7:0]        bus_rdata_o,
    input  logic              cmd_valid_i,
    input  logic              cmd_op_i,
    input  logic [7:0]        cmd_char_i,
    input  logic [7:0]        cmd_col_i,
    output logic              cmd_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] ch_map_addr_o,
    output logic [7:0]        ch_map_data_o,
    output logic              ch_map_wen_o,
    input  logic [7:0]        ch_map_data_i,
    output logic [ADDR_W-1:0] col_map_addr_o,
    output logic [7:0]        col_map_data_o,
    output logic              col_map_wen_o,
    input  logic [7:0]        col_map_data_i
);

    typedef enum logic [2:0] {StIdle, StFill, StScRd, StScWr, StScClr} state_e;

    localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LastMove = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] RowOff   = ADDR_W'(COLS);

    state_e            state_q;
    logic [ADDR_W-1:0] a_q;
    logic [7:0]        char_q;
    logic [7:0]        col_q;
    logic              done_q;
    logic              rvalid_q;
    logic              rsel_q;
    logic [7:0]        rdata_q;
    logic [7:0]        rd_sel;
    logic              idle;

    assign idle         = (state_q == StIdle);
    assign rd_sel       = rsel_q ? col_map_data_i : ch_map_data_i;
    assign bus_gnt_o    = idle & bus_req_i;
    assign cmd_ready_o  = idle & ~bus_req_i;
    assign busy_o       = ~idle;
    assign done_o       = done_q;
    assign bus_rvalid_o = rvalid_q;
    // Read data is live in the rvalid cycle and held from the register afterwards.
    assign bus_rdata_o  = rvalid_q ? rd_sel : rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            a_q      <= '0;
            char_q   <= '0;
            col_q    <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rsel_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            if (rvalid_q) begin
                rdata_q <= rd_sel;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus_req_i) begin
                        if (!bus_we_i) begin
                            rvalid_q <= 1'b1;
                            rsel_q   <= bus_sel_i;
                        end
                    end else if (cmd_valid_i) begin
                        char_q  <= cmd_char_i;
                        col_q   <= cmd_col_i;
                        a_q     <= '0;
                        state_q <= cmd_op_i ? StScRd : StFill;
                    end
                end
                StFill, StScClr: begin
                    a_q <= a_q + 1'b1;
                    if (a_q == LastCell) begin
                        a_q     <= '0;
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                StScRd: begin
                    state_q <= StScWr;
                end
                StScWr: begin
                    a_q     <= a_q + 1'b1;
                    state_q <= (a_q == LastMove) ? StScClr : StScRd;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        ch_map_addr_o  = bus_addr_i;
        col_map_addr_o = bus_addr_i;
        ch_map_data_o  = bus_wdata_i;
        col_map_data_o = bus_wdata_i;
        ch_map_wen_o   = 1'b0;
        col_map_wen_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ch_map_wen_o  = bus_req_i & bus_we_i & ~bus_sel_i;
                col_map_wen_o = bus_req_i & bus_we_i & bus_sel_i;
            end
            StFill, StScClr: begin
                ch_map_addr_o  = a_q;
                col_map_addr_o = a_q;
                ch_map_data_o  = char_q;
                col_map_data_o = col_q;
                ch_map_wen_o   = 1'b1;
                col_map_wen_o  = 1'b1;
            end
            StScRd: begin
                ch_map_addr_o  = a_q + RowOff;
                col_map_addr_o = a_q + RowOff;
            end
            StScWr: begin
                // Write back the cell one row below, read in the preceding cycle.
                ch_map_addr_o  = a_q;
                col_map_addr_o = a_q;
                ch_map_data_o  = ch_map_data_i;
                col_map_data_o = col_map_data_i;
                ch_map_wen_o   = 1'b1;
                col_map_wen_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_vgachargen_map_ctrl.sv
// Bench for vgachargen_map_ctrl: map RAM models, a screen-level reference model checked
// every cycle, and directed plus randomized bus and command traffic.
module tb_vgachargen_map_ctrl;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam int MOVE  = COLS * (ROWS - 1);
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          bus_req = 1'b0;
    logic          bus_we = 1'b0;
    logic          bus_sel = 1'b0;
    logic [AW-1:0] bus_addr = '0;
    logic [7:0]    bus_wdata = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_op = 1'b0;
    logic [7:0]    cmd_char = '0;
    logic [7:0]    cmd_col = '0;
    logic          bus_gnt, bus_rvalid, cmd_ready, busy, done;
    logic [7:0]    bus_rdata;
    logic [AW-1:0] ch_addr, col_addr;
    logic [7:0]    ch_wdata, col_wdata, ch_rd, col_rd;
    logic          ch_wen, col_wen;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vgachargen_map_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .bus_req_i     (bus_req),
        .bus_we_i      (bus_we),
        .bus_sel_i     (bus_sel),
        .bus_addr_i    (bus_addr),
        .bus_wdata_i   (bus_wdata),
        .bus_gnt_o     (bus_gnt),
        .bus_rvalid_o  (bus_rvalid),
        .bus_rdata_o   (bus_rdata),
        .cmd_valid_i   (cmd_valid),
        .cmd_op_i      (cmd_op),
        .cmd_char_i    (cmd_char),
        .cmd_col_i     (cmd_col),
        .cmd_ready_o   (cmd_ready),
        .busy_o        (busy),
        .done_o        (done),
        .ch_map_addr_o (ch_addr),
        .ch_map_data_o (ch_wdata),
        .ch_map_wen_o  (ch_wen),
        .ch_map_data_i (ch_rd),
        .col_map_addr_o(col_addr),
        .col_map_data_o(col_wdata),
        .col_map_wen_o (col_wen),
        .col_map_data_i(col_rd)
    );

    // Synchronous single-port maps, one cycle read latency.
    logic [7:0] ram_ch  [CELLS];
    logic [7:0] ram_col [CELLS];
    always @(posedge clk) begin
        if (ch_wen) ram_ch[ch_addr] <= ch_wdata;
        if (col_wen) ram_col[col_addr] <= col_wdata;
        ch_rd  <= ram_ch[ch_addr];
        col_rd <= ram_col[col_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 fill, 2 scroll; k counts cycles since accept.
    logic [7:0] sh_ch  [CELLS];
    logic [7:0] sh_col [CELLS];
    logic [7:0] pre_ch [CELLS];
    logic [7:0] pre_col[CELLS];
    int         m_mode;
    int         m_k;
    logic [7:0] m_ch, m_col, m_rd;
    logic       m_done, m_rv;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_mode <= 0;
            m_k    <= 0;
            m_done <= 1'b0;
            m_rv   <= 1'b0;
            m_rd   <= 8'h00;
        end else begin
            m_done <= 1'b0;
            m_rv   <= 1'b0;
            if (m_mode == 0) begin
                if (bus_req) begin
                    if (bus_we) begin
                        if (bus_sel) sh_col[bus_addr] <= bus_wdata;
                        else sh_ch[bus_addr] <= bus_wdata;
                    end else begin
                        m_rv <= 1'b1;
                        m_rd <= bus_sel ? sh_col[bus_addr] : sh_ch[bus_addr];
                    end
                end else if (cmd_valid) begin
                    m_mode <= cmd_op ? 2 : 1;
                    m_k    <= 0;
                    m_ch   <= cmd_char;
                    m_col  <= cmd_col;
                    for (int i = 0; i < CELLS; i++) begin
                        pre_ch[i]  <= sh_ch[i];
                        pre_col[i] <= sh_col[i];
                    end
                end
            end else if (m_mode == 1) begin
                sh_ch[m_k]  <= m_ch;
                sh_col[m_k] <= m_col;
                m_k <= m_k + 1;
                if (m_k == CELLS - 1) begin
                    m_mode <= 0;
                    m_done <= 1'b1;
                end
            end else begin
                if (m_k >= 2 * MOVE) begin
                    sh_ch[m_k - MOVE]  <= m_ch;
                    sh_col[m_k - MOVE] <= m_col;
                end else if (m_k % 2 == 1) begin
                    sh_ch[m_k / 2]  <= pre_ch[m_k / 2 + COLS];
                    sh_col[m_k / 2] <= pre_col[m_k / 2 + COLS];
                end
                m_k <= m_k + 1;
                if (m_k == 2 * MOVE + COLS - 1) begin
                    m_mode <= 0;
                    m_done <= 1'b1;
                end
            end
        end
    end

    int         e_addr;
    logic       e_wch, e_wcol;
    logic [7:0] e_dch, e_dcol;
    int         maxrd;

    always @(negedge clk) begin
        if (rst_ni) begin
            e_addr = int'(bus_addr);
            e_wch  = bus_req & bus_we & ~bus_sel;
            e_wcol = bus_req & bus_we & bus_sel;
            e_dch  = bus_wdata;
            e_dcol = bus_wdata;
            if (m_mode == 1) begin
                e_addr = m_k;
                e_wch = 1'b1; e_wcol = 1'b1; e_dch = m_ch; e_dcol = m_col;
            end else if (m_mode == 2) begin
                if (m_k >= 2 * MOVE) begin
                    e_addr = m_k - MOVE;
                    e_wch = 1'b1; e_wcol = 1'b1; e_dch = m_ch; e_dcol = m_col;
                end else if (m_k % 2 == 0) begin
                    e_addr = m_k / 2 + COLS;
                    e_wch = 1'b0; e_wcol = 1'b0;
                end else begin
                    e_addr = m_k / 2;
                    e_wch = 1'b1; e_wcol = 1'b1;
                    e_dch = pre_ch[m_k / 2 + COLS];
                    e_dcol = pre_col[m_k / 2 + COLS];
                end
            end
            check("busy", busy, m_mode != 0);
            check("done", done, m_done);
            check("gnt", bus_gnt, (m_mode == 0) && bus_req);
            check("cmd_ready", cmd_ready, (m_mode == 0) && !bus_req);
            check("rvalid", bus_rvalid, m_rv);
            check("rdata", bus_rdata, m_rd);
            check("ch_wen", ch_wen, e_wch);
            check("col_wen", col_wen, e_wcol);
            check("ch_addr", ch_addr, e_addr);
            check("col_addr", col_addr, e_addr);
            if (e_wch) check("ch_wdata", ch_wdata, e_dch);
            if (e_wcol) check("col_wdata", col_wdata, e_dcol);
            if (m_mode != 2) begin
                maxrd = -1;
            end else if (!ch_wen) begin
                maxrd = int'(ch_addr);
            end else if (int'(ch_addr) >= COLS) begin
                check("scroll_read_before_write", int'(ch_addr) <= maxrd, 1);
            end
        end
    end

    task automatic bus_op(input logic we, input logic sel, input int addr, input logic [7:0] wd,
                          output int wait_cyc, output logic chw, output logic colw,
                          output logic rv, output logic [7:0] rd);
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = we; bus_sel = sel; bus_addr = AW'(addr); bus_wdata = wd;
        wait_cyc = -1; chw = 1'b0; colw = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (bus_gnt) begin
                wait_cyc = i; chw = ch_wen; colw = col_wen;
                break;
            end
        end
        check("bus_granted", wait_cyc >= 0, 1);
        @(posedge clk); #1;
        bus_req = 1'b0;
        @(negedge clk);
        rv = bus_rvalid;
        rd = bus_rdata;
    endtask

    task automatic run_cmd(input logic op, input logic [7:0] ch, input logic [7:0] col,
                           output int nbusy);
        int ndone;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_char = ch; cmd_col = col;
        @(negedge clk);
        check("cmd_accept_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        nbusy = 0; ndone = 0;
        for (int i = 0; i < 6000 && ndone == 0; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) ndone++;
        end
        check("cmd_done_seen", ndone, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("cmd_single_done", ndone, 1);
    endtask

    initial begin
        int         wc, nb, a;
        logic       chw, colw, rv, got;
        logic [7:0] rd, fch, fcol;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rvalid", bus_rvalid, 0);
        check("rst_rdata", bus_rdata, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_ch_wen", ch_wen, 0);
        #1 rst_ni = 1'b1;

        // Bus write/read of cell 5.
        bus_op(1'b1, 1'b0, 5, 8'h41, wc, chw, colw, rv, rd);
        check("t1_wr_ch_wait", wc, 0);
        check("t1_wr_ch_chwen", chw, 1);
        check("t1_wr_ch_colwen", colw, 0);
        bus_op(1'b1, 1'b1, 5, 8'h0F, wc, chw, colw, rv, rd);
        check("t1_wr_col_chwen", chw, 0);
        check("t1_wr_col_colwen", colw, 1);
        bus_op(1'b0, 1'b0, 5, 8'h00, wc, chw, colw, rv, rd);
        check("t1_rd_ch_wait", wc, 0);
        check("t1_rd_ch_rvalid", rv, 1);
        check("t1_rd_ch_data", rd, 8'h41);
        bus_op(1'b0, 1'b1, 5, 8'h00, wc, chw, colw, rv, rd);
        check("t1_rd_col_data", rd, 8'h0F);

        // Arbitration, then FILL with a bus read held pending for its whole duration.
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b0; bus_sel = 1'b0; bus_addr = AW'(5);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_char = 8'h20; cmd_col = 8'h07;
        @(negedge clk);
        check("arb_gnt", bus_gnt, 1);
        check("arb_ready", cmd_ready, 0);
        @(posedge clk); #1;
        bus_req = 1'b0;
        @(negedge clk);
        check("arb_ready_after", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        bus_req = 1'b1; bus_addr = AW'(CELLS - 1);
        nb = 0; got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (bus_gnt) begin
                got = 1'b1;
                check("fill_gnt_in_done_cycle", done, 1);
            end
        end
        check("fill_bus_granted", got, 1);
        check("fill_busy_cycles", nb, 2400);
        @(posedge clk); #1;
        bus_req = 1'b0;
        @(negedge clk);
        check("fill_rd_2399", bus_rdata, 8'h20);

        // Random bus traffic, checked by the model.
        for (int i = 0; i < 60; i++) begin
            bus_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, CELLS - 1)), 8'($urandom), wc, chw, colw, rv, rd);
        end

        // Preload both maps with cell = addr[7:0], back-to-back writes.
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < CELLS; c++) begin
                bus_sel = 1'(s); bus_addr = AW'(c); bus_wdata = 8'(c);
                @(posedge clk); #1;
            end
        end
        bus_req = 1'b0; bus_we = 1'b0;

        run_cmd(1'b1, 8'h00, 8'h1E, nb);
        check("scroll_busy_cycles", nb, 4720);
        bus_op(1'b0, 1'b0, 0, 8'h00, wc, chw, colw, rv, rd);
        check("scroll_ch_0", rd, 8'h50);
        bus_op(1'b0, 1'b0, 1000, 8'h00, wc, chw, colw, rv, rd);
        check("scroll_ch_1000", rd, 8'h38);
        bus_op(1'b0, 1'b1, 2319, 8'h00, wc, chw, colw, rv, rd);
        check("scroll_col_2319", rd, 8'h5F);
        bus_op(1'b0, 1'b0, 2320, 8'h00, wc, chw, colw, rv, rd);
        check("scroll_ch_2320", rd, 8'h00);
        bus_op(1'b0, 1'b1, 2399, 8'h00, wc, chw, colw, rv, rd);
        check("scroll_col_2399", rd, 8'h1E);
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(0, CELLS - 1));
            bus_op(1'b0, 1'b0, a, 8'h00, wc, chw, colw, rv, rd);
            check("scroll_rand_ch", rd, (a < MOVE) ? 8'(a + COLS) : 8'h00);
        end

        // Asynchronous reset in the middle of a SCROLL.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_char = 8'h2A; cmd_col = 8'h33;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (1000) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_ch_wen", ch_wen, 0);
        check("rst_mid_col_wen", col_wen, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        repeat (2) @(negedge clk);
        #1 rst_ni = 1'b1;
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) nb++;
        end
        check("rst_no_done", nb, 0);
        fch = 8'($urandom); fcol = 8'($urandom);
        run_cmd(1'b0, fch, fcol, nb);
        check("post_rst_fill_busy", nb, 2400);
        a = int'($urandom_range(0, CELLS - 1));
        bus_op(1'b0, 1'b1, a, 8'h00, wc, chw, colw, rv, rd);
        check("post_rst_fill_col", rd, fcol);

        // Back-to-back FILL then SCROLL with cmd_valid held.
        fch = 8'($urandom); fcol = 8'($urandom);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_char = fch; cmd_col = fcol;
        @(negedge clk);
        check("b2b_first_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_op = 1'b1; cmd_char = 8'h2E; cmd_col = 8'h70;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("b2b_ready_in_done", cmd_ready, 1);
            end
        end
        check("b2b_fill_done", got, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        nb = 0; got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clk);
            if (i == 0) check("b2b_no_gap", busy, 1);
            if (busy) nb++;
            if (done) got = 1'b1;
        end
        check("b2b_scroll_done", got, 1);
        check("b2b_scroll_busy", nb, 4720);
        bus_op(1'b0, 1'b0, 0, 8'h00, wc, chw, colw, rv, rd);
        check("b2b_ch_0", rd, fch);
        bus_op(1'b0, 1'b1, 2399, 8'h00, wc, chw, colw, rv, rd);
        check("b2b_col_2399", rd, 8'h70);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
